// File: rtl/spi_ram_pkg.sv
// Shared command encoding, word layout and default geometry for the SPI-fed RAM.
// Pulled in by spi_ram_ctrl, spi_ram_mem and the interface.
package spi_ram_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int MEM_DEPTH_DEF = 256;
    localparam int DATA_W        = 8;
    localparam int WORD_W        = 10;

    // Two-bit opcode carried in din[9:8].
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // Layout of the 10-bit word handed over by the SPI slave.
    typedef struct packed {
        cmd_e              cmd;
        logic [DATA_W-1:0] payload;
    } rx_word_t;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Parallel word hand-off between the SPI slave (master side) and the RAM controller
// (slave side): command word in, read data and status out.
interface spi_ram_ctrl_if;
    import spi_ram_pkg::*;

    logic [WORD_W-1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              cmd_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  cmd_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output cmd_err
    );

endinterface

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with a registered read port that only updates on a read,
// so the read register doubles as the held output word.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // NOTE: the array has no reset so it can map onto a RAM macro; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM behind the SPI slave: address load, write and read commands on din[9:8].
// Define SPI_RAM_AUTOINC_EN to post-increment the write/read address after each data access.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input logic           clk,
    input logic           rst,
    spi_ram_ctrl_if.slave bus
);

    rx_word_t             word;
    logic                 rx_valid_q;
    logic                 accept;

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 wr_addr_ok;
    logic                 rd_addr_ok;

    logic                 wr_addr_ld;
    logic                 rd_addr_ld;
    logic                 mem_we;
    logic                 mem_re;
    logic                 reject;
    logic                 tx_clear;

    logic                 tx_valid_r;
    logic                 cmd_err_r;
    logic [DATA_W-1:0]    rd_data;

    assign word   = rx_word_t'(bus.din);
    assign accept = bus.rx_valid & ~rx_valid_q;

    // Resetting the history to 1 means a level held across reset release is not a new word.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b1;
        end else begin
            rx_valid_q <= bus.rx_valid;
        end
    end

    // NOTE: every output gets a default first, so no branch can leave one unassigned (no latch).
    always_comb begin
        wr_addr_ld = 1'b0;
        rd_addr_ld = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        reject     = 1'b0;
        tx_clear   = 1'b0;
        if (accept) begin
            unique case (word.cmd)
                CMD_WR_ADDR: begin
                    wr_addr_ld = 1'b1;
                    tx_clear   = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (wr_addr_ok) begin
                        mem_we   = 1'b1;
                        tx_clear = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_ld = 1'b1;
                    tx_clear   = 1'b1;
                end
                CMD_RD_DATA: begin
                    if (rd_addr_ok) begin
                        mem_re = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr    <= '0;
            wr_addr_ok <= 1'b0;
        end else if (wr_addr_ld) begin
            wr_addr    <= word.payload[ADDR_SIZE-1:0];
            wr_addr_ok <= 1'b1;
        end
`ifdef SPI_RAM_AUTOINC_EN
        else if (mem_we) begin
            wr_addr <= wr_addr + ADDR_SIZE'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            rd_addr_ok <= 1'b0;
        end else if (rd_addr_ld) begin
            rd_addr    <= word.payload[ADDR_SIZE-1:0];
            rd_addr_ok <= 1'b1;
        end
`ifdef SPI_RAM_AUTOINC_EN
        else if (mem_re) begin
            rd_addr <= rd_addr + ADDR_SIZE'(1);
        end
`endif
    end

    // A rejected command leaves tx_valid alone; any accepted non-read clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid_r <= 1'b0;
            cmd_err_r  <= 1'b0;
        end else begin
            cmd_err_r <= reject;
            if (mem_re) begin
                tx_valid_r <= 1'b1;
            end else if (tx_clear) begin
                tx_valid_r <= 1'b0;
            end
        end
    end

    // Writes and reads never coincide, so one port serves both address registers.
    assign mem_addr = mem_re ? rd_addr : wr_addr;

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (word.payload),
        .rdata (rd_data)
    );

    assign bus.dout     = rd_data;
    assign bus.tx_valid = tx_valid_r;
    assign bus.cmd_err  = cmd_err_r;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed vector table, multi-cycle corner cases,
// and randomized commands scored against a behavioural command model.
module tb_spi_ram_ctrl;

`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_ram_ctrl_if bus ();

    spi_ram_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic [7:0] m_mem [256];
    logic [7:0] m_wr;
    logic [7:0] m_rd;
    logic [7:0] m_dout;
    logic       m_wok;
    logic       m_rok;
    logic       m_tx;

    typedef struct {
        logic [9:0] din;
        logic [7:0] dout;
        logic       tx;
        logic       err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr   = 8'h00;
        m_rd   = 8'h00;
        m_dout = 8'h00;
        m_wok  = 1'b0;
        m_rok  = 1'b0;
        m_tx   = 1'b0;
    endtask

    task automatic model_cmd(input logic [9:0] d, output logic [7:0] e_dout,
                             output logic e_tx, output logic e_err);
        logic [7:0] p;
        p     = d[7:0];
        e_err = 1'b0;
        case (d[9:8])
            2'b00: begin
                m_wr  = p;
                m_wok = 1'b1;
                m_tx  = 1'b0;
            end
            2'b01: begin
                if (m_wok) begin
                    m_mem[m_wr] = p;
                    m_tx        = 1'b0;
                    if (AUTOINC) m_wr = m_wr + 8'd1;
                end else begin
                    e_err = 1'b1;
                end
            end
            2'b10: begin
                m_rd  = p;
                m_rok = 1'b1;
                m_tx  = 1'b0;
            end
            default: begin
                if (m_rok) begin
                    m_dout = m_mem[m_rd];
                    m_tx   = 1'b1;
                    if (AUTOINC) m_rd = m_rd + 8'd1;
                end else begin
                    e_err = 1'b1;
                end
            end
        endcase
        e_dout = m_dout;
        e_tx   = m_tx;
    endtask

    // One rx_valid pulse; returns at the falling edge after the accepting edge.
    task automatic pulse(input logic [9:0] d);
        @(posedge clk);
        #1;
        bus.din      = d;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [9:0] d, input string name);
        logic [7:0] ed;
        logic       et;
        logic       ee;
        model_cmd(d, ed, et, ee);
        pulse(d);
        check({name, " dout"}, 32'(bus.dout), 32'(ed));
        check({name, " tx_valid"}, 32'(bus.tx_valid), 32'(et));
        check({name, " cmd_err"}, 32'(bus.cmd_err), 32'(ee));
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ed;
        logic       et;
        logic       ee;

        vecs[0] = '{10'h0A5, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{10'h13C, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{10'h2A5, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{10'h300, 8'h3C, 1'b1, 1'b0};
        vecs[4] = '{10'h010, 8'h3C, 1'b0, 1'b0};
        vecs[5] = '{10'h000, 8'h3C, 1'b0, 1'b0};
        vecs[6] = '{10'h1AA, 8'h3C, 1'b0, 1'b0};
        vecs[7] = '{10'h200, 8'h3C, 1'b0, 1'b0};
        vecs[8] = '{10'h300, 8'hAA, 1'b1, 1'b0};

        bus.din      = '0;
        bus.rx_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset dout", 32'(bus.dout), 32'h0);
        check("reset tx_valid", 32'(bus.tx_valid), 32'h0);
        check("reset cmd_err", 32'(bus.cmd_err), 32'h0);

        // Directed table: write/read round trip, then tx_valid drop on a new command.
        for (int i = 0; i < 9; i++) begin
            model_cmd(vecs[i].din, ed, et, ee);
            pulse(vecs[i].din);
            check($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(vecs[i].dout));
            check($sformatf("vec%0d tx_valid", i), 32'(bus.tx_valid), 32'(vecs[i].tx));
            check($sformatf("vec%0d cmd_err", i), 32'(bus.cmd_err), 32'(vecs[i].err));
        end

        // Read result is held while the bus is idle.
        repeat (5) @(negedge clk);
        check("hold dout", 32'(bus.dout), 32'hAA);
        check("hold tx_valid", 32'(bus.tx_valid), 32'h1);

        // Out-of-order data commands straight after reset are rejected.
        do_reset();
        check("reset2 dout", 32'(bus.dout), 32'h0);
        check("reset2 tx_valid", 32'(bus.tx_valid), 32'h0);
        do_cmd(10'h155, "early wr_data");
        @(negedge clk);
        check("cmd_err width", 32'(bus.cmd_err), 32'h0);
        do_cmd(10'h300, "early rd_data");
        do_cmd(10'h200, "rd_addr 0");
        do_cmd(10'h300, "rd_data 0");
        check("mem0 unchanged", 32'(bus.dout), 32'hAA);

        // Reset between RD_ADDR and RD_DATA with rx_valid held across release.
        do_cmd(10'h2A5, "pre-reset rd_addr");
        @(posedge clk);
        #1;
        bus.din      = 10'h300;
        bus.rx_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async reset dout", 32'(bus.dout), 32'h0);
        check("async reset tx_valid", 32'(bus.tx_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("held-through-reset cmd_err c%0d", i), 32'(bus.cmd_err), 32'h0);
            check($sformatf("held-through-reset dout c%0d", i), 32'(bus.dout), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        do_cmd(10'h300, "post-reset rd_data");

        // Fill the whole array so every later read has a known expectation.
        for (int a = 0; a < 256; a++) begin
            do_cmd({2'b00, 8'(a)}, "init addr");
            do_cmd({2'b01, 8'(a) ^ 8'h5A}, "init data");
        end

        // A level held for 12 cycles is a single command.
        do_cmd(10'h040, "hold wr_addr");
        model_cmd(10'h177, ed, et, ee);
        @(posedge clk);
        #1;
        bus.din      = 10'h177;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("long rx_valid cmd_err c%0d", i), 32'(bus.cmd_err), 32'(ee));
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        do_cmd(10'h188, "after hold wr_data");
        do_cmd(10'h240, "hold rd_addr");
        do_cmd(10'h300, "hold rd 0");
`ifdef SPI_RAM_AUTOINC_EN
        check("hold single write 0x40", 32'(bus.dout), 32'h77);
`else
        check("hold overwrite 0x40", 32'(bus.dout), 32'h88);
`endif
        do_cmd(10'h300, "hold rd 1");
        do_cmd(10'h300, "hold rd 2");
`ifdef SPI_RAM_AUTOINC_EN
        check("hold untouched 0x42", 32'(bus.dout), 32'h42 ^ 32'h5A);
`endif

        // Address wrap at the top of the array.
        do_cmd(10'h0FF, "wrap wr_addr");
        do_cmd(10'h111, "wrap wr 11");
        do_cmd(10'h122, "wrap wr 22");
        do_cmd(10'h2FF, "wrap rd_addr");
        do_cmd(10'h300, "wrap rd 0");
`ifdef SPI_RAM_AUTOINC_EN
        check("wrap mem[ff]", 32'(bus.dout), 32'h11);
`else
        check("static mem[ff]", 32'(bus.dout), 32'h22);
`endif
        do_cmd(10'h300, "wrap rd 1");
`ifdef SPI_RAM_AUTOINC_EN
        check("wrap mem[00]", 32'(bus.dout), 32'h22);
`else
        check("static mem[ff] again", 32'(bus.dout), 32'h22);
`endif

        // Randomized commands from a fresh reset, with random idle gaps.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [9:0] d;
            int         gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            d = 10'($urandom);
            do_cmd(d, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Command-decoding single-port RAM that sits directly downstream of the SPI slave. It consumes the SPI slave's 10-bit parallel word (`rx_data`/`rx_valid`), interprets bits [9:8] as a command, and performs address-load, write, or read operations. It returns read data to the SPI slave via `tx_data`/`tx_valid` for serialisation on MISO.

## Interface
- `MEM_DEPTH`, default 256: number of 8-bit words; must equal 2**`ADDR_SIZE`.
- `ADDR_SIZE`, default 8: address width.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `din`  input  10  command word from the SPI slave: [9:8] command, [7:0] address or data.
- `rx_valid`  input  1  word valid; may stay high for many cycles per word.
- `dout`  output  8  read data to the SPI slave (its `tx_data`).
- `tx_valid`  output  1  `dout` holds fresh read data.
- `cmd_err`  output  1  one-cycle pulse: out-of-order command rejected.

## Operation
- Command acceptance: a word is accepted only on a rising edge of `rx_valid`, i.e. `rx_valid`=1 while the registered `rx_valid_q`=0. A level held for any duration counts as one command.
- Commands, by `din[9:8]`:
  - 00 (WR_ADDR): `wr_addr` <= `din[7:0]`; set `wr_addr_ok`.
  - 01 (WR_DATA): if `wr_addr_ok`, `mem[wr_addr]` <= `din[7:0]`; otherwise reject.
  - 10 (RD_ADDR): `rd_addr` <= `din[7:0]`; set `rd_addr_ok`; clear `tx_valid`.
  - 11 (RD_DATA): if `rd_addr_ok`, `dout` <= `mem[rd_addr]` and `tx_valid` <= 1; otherwise reject. `din[7:0]` is a don't-care.
- Reject: no state change, except that `cmd_err` pulses high for exactly one cycle.
- `tx_valid` holds 1 until the next accepted command of any type, which clears it in the same cycle. An accepted RD_DATA re-asserts it.
- `dout` holds its value between reads and changes only on an accepted RD_DATA.
- Addresses are `ADDR_SIZE` bits. Without auto-increment they never change except on a load command.
- Reset values: `dout`=0, `tx_valid`=0, `cmd_err`=0, `wr_addr`=0, `rd_addr`=0, `wr_addr_ok`=0, `rd_addr_ok`=0, `rx_valid_q`=1.
- Memory contents are not reset.

## Timing
- One registered stage. Command accepted at clock edge N:
  - Address registers and memory write take effect at edge N.
  - `dout`, `tx_valid` and `cmd_err` are visible after edge N.
- A read accepted at least one cycle after a write to the same address returns the new data. No write-through bypass is needed, since acceptances are always at least two cycles apart.
- Reset mid-operation: all registers clear asynchronously.
- Because `rx_valid_q` resets to 1, an `rx_valid` held high across reset release is not accepted. The next rising edge is accepted.
- Throughput: one command per `rx_valid` low-to-high transition. The minimum spacing is 2 cycles.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined:
  - An accepted WR_DATA increments `wr_addr` by 1 modulo `MEM_DEPTH` (0xFF wraps to 0x00).
  - An accepted RD_DATA increments `rd_addr` likewise, after the read.
  - `wr_addr_ok` and `rd_addr_ok` remain set.
- Not defined: addresses are static between load commands.

## Structure
- Package `spi_ram_pkg`:
  - Command encoding constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
  - Default `ADDR_SIZE` and `MEM_DEPTH`.
- Sub-module `spi_ram_mem`: single-port synchronous array (write enable, address, write data, registered read data), sized by the parameters.
- `spi_ram_ctrl` contains:
  - edge detect
  - command decode
  - address and ordering-flag registers
  - `tx_valid` and `cmd_err` logic
  - the address-select mux into the single port

## Test plan
- Reset, then pulse `din`=0x0A5 (WR_ADDR 0xA5), `din`=0x13C (WR_DATA 0x3C), `din`=0x2A5 (RD_ADDR 0xA5), `din`=0x300 (RD_DATA) -> `dout`=0x3C and `tx_valid`=1 one cycle after the RD_DATA accept, both held until the next command.
- Right after reset, send `din`=0x155 (WR_DATA) then `din`=0x300 (RD_DATA) -> `cmd_err` pulses one cycle each, `tx_valid` stays 0, memory is unchanged.
- Hold `rx_valid`=1 for 12 cycles with WR_DATA 0x77 under `SPI_RAM_AUTOINC_EN` -> exactly one write and `wr_addr` +1.
- With `SPI_RAM_AUTOINC_EN`: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> `mem[0xFF]`=0x11, `mem[0x00]`=0x22 (wrap-around).
- Assert `rst` between RD_ADDR and RD_DATA with `rx_valid` held high across release -> outputs 0, no accept until `rx_valid` falls and rises, then RD_DATA gives `cmd_err` (`rd_addr_ok` was cleared).
- After a read sets `tx_valid`=1, send WR_ADDR 0x010 -> `tx_valid` drops after that edge, `dout` unchanged.
